peaks_scheduler: RTL
====================

Name: peaks_scheduler

Overview:
- Sequences FFT frames into the `peaks` block.
- Turns FFT-done strobes into correctly spaced single-cycle `valid_in` pulses, holding at most one frame pending.
- Detects each new `peaks` result by watching `counter_out` change, and discards pipeline-priming results.
- Buffers results in a small FIFO and delivers them downstream (fingerprint hasher / Avalon reader) over a valid/ready handshake, with overrun and drop counters.

Parameters:
- MIN_GAP, 320: minimum clk cycles between successive `peaks_valid` rising edges; must be ≥ FREQS + max bin width + 3.
- PEAKS, 6: peaks per frame.
- FREQ_WIDTH, 8: width of one frequency index.
- AMPL_WIDTH, 8: width of one final amplitude.
- TIME_WIDTH, 16: width of `counter_out` and `res_frame`.
- FIFO_DEPTH, 2: result FIFO entries; power of two, ≥ 2.
- DISCARD, 2: results dropped after reset or flush.
- CNT_WIDTH, 8: width of the saturating overrun and drop counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous clear of pending frame, FIFO and discard count; `peaks` itself is not reset.
- fft_valid  in  1  one-cycle strobe: a new FFT frame is present on the `fft_in` bus.
- peaks_valid  out  1  drives `peaks.valid_in`; one cycle high per issued frame.
- peaks_counter  in  TIME_WIDTH  `peaks.counter_out`.
- peaks_freqs  in  PEAKS*FREQ_WIDTH  flattened `peaks.freqs_out`; entry 0 in the LSBs.
- peaks_ampls  in  PEAKS*AMPL_WIDTH  flattened `peaks.amplitudes_out`; entry 0 in the LSBs.
- res_valid  out  1  FIFO head valid.
- res_ready  in  1  downstream accepts the head.
- res_freqs  out  PEAKS*FREQ_WIDTH  head frequencies.
- res_ampls  out  PEAKS*AMPL_WIDTH  head amplitudes.
- res_frame  out  TIME_WIDTH  sequence number of the head result; 0 for the first kept result.
- busy  out  1  high while in ISSUE or GAP state, or while a frame is pending.
- overrun_count  out  CNT_WIDTH  saturating count of dropped FFT frames.
- drop_count  out  CNT_WIDTH  saturating count of results lost to a full FIFO.

Behaviour:
- Reset values: all outputs 0; state IDLE; pending 0; discard counter = DISCARD; `prev_counter` 0; FIFO empty; frame sequence 0.
- Issue FSM states:
  - IDLE: if `fft_valid` or pending, go to ISSUE.
  - ISSUE: `peaks_valid`=1 for exactly this cycle; load gap counter with MIN_GAP-1; go to GAP.
  - GAP: decrement the gap counter. At 0, go to ISSUE if pending or `fft_valid` this cycle, else IDLE.
- Issue latency: `fft_valid` at edge N in IDLE gives `peaks_valid` high during cycle N+1. Consecutive `peaks_valid` pulses are never less than MIN_GAP cycles apart.
- Pending flag (one deep):
  - Set by `fft_valid` in ISSUE or GAP.
  - Cleared on entering ISSUE.
  - `fft_valid` while pending is already 1 and not being consumed in that cycle: frame dropped, `overrun_count`++ (saturating at all-ones).
  - `fft_valid` in the same cycle the pending frame moves to ISSUE: re-sets pending; no overrun.
- Result detection:
  - Register `peaks_counter` each cycle into `prev_counter`.
  - `peaks_counter` != `prev_counter` is a new result; `peaks_freqs`/`peaks_ampls` are sampled in that same cycle.
  - Wrap-around of `peaks_counter` is an ordinary change.
  - Reset: `prev_counter` = 0, matching `peaks` reset.
- Discard: while the discard counter > 0, each new result decrements it and is not pushed.
- FIFO:
  - Kept results are pushed with `res_frame` = frame sequence, which then increments (wraps at TIME_WIDTH).
  - Push when full with no pop that cycle: result dropped, sequence still increments, `drop_count`++ (saturating).
  - Push and pop in the same cycle on a full FIFO: both succeed.
  - Pop occurs when `res_valid` & `res_ready`. Head outputs hold stable while `res_valid` & !`res_ready`.
  - Push-to-`res_valid` latency: one cycle.
- flush:
  - Clears pending, FIFO and frame sequence; reloads the discard counter.
  - Does not clear the FSM, gap counter, `prev_counter` or the two error counters.
  - An in-flight ISSUE/GAP completes.
  - flush together with `fft_valid` in IDLE: frame is accepted.
- Reset mid-operation: asynchronous. `peaks_valid` drops immediately and every register returns to its reset value.

Test Plan:
- Single frame: `fft_valid` at cycle 10 → `peaks_valid` high only in cycle 11; `busy` high from cycle 11 through cycle 11+MIN_GAP-1.
- Back-to-back frames: `fft_valid` at cycles 10, 20, 30 → pulses at 11 and 11+MIN_GAP; frame 3 dropped; `overrun_count`=1.
- Discard and tagging: model `peaks_counter` stepping 0→1→2→3→4 with distinct freqs → first 2 results discarded; results 3 and 4 delivered with `res_frame` 0 and 1, data matching.
- Backpressure: `res_ready`=0 with 4 kept results arriving (DEPTH 2) → 2 buffered, `drop_count`=2, head stable. Raising `res_ready` yields `res_frame` 0 then 1.
- Counter wrap: `peaks_counter` FFFF→0000 → detected as a new result.
- Async reset asserted during GAP with pending=1 → all outputs 0 immediately; no `peaks_valid` after release until a new `fft_valid`.

Source files
------------

// File: rtl/peaks_scheduler.sv
// Paces FFT frames into the peaks block and collects its results into a small
// FIFO for a valid/ready consumer, with overrun and drop counters.
module peaks_scheduler #(
  parameter int MIN_GAP    = 320,
  parameter int PEAKS      = 6,
  parameter int FREQ_WIDTH = 8,
  parameter int AMPL_WIDTH = 8,
  parameter int TIME_WIDTH = 16,
  parameter int FIFO_DEPTH = 2,
  parameter int DISCARD    = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        fft_valid,
  output logic                        peaks_valid,
  input  logic [TIME_WIDTH-1:0]       peaks_counter,
  input  logic [PEAKS*FREQ_WIDTH-1:0] peaks_freqs,
  input  logic [PEAKS*AMPL_WIDTH-1:0] peaks_ampls,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [PEAKS*FREQ_WIDTH-1:0] res_freqs,
  output logic [PEAKS*AMPL_WIDTH-1:0] res_ampls,
  output logic [TIME_WIDTH-1:0]       res_frame,
  output logic                        busy,
  output logic [CNT_WIDTH-1:0]        overrun_count,
  output logic [CNT_WIDTH-1:0]        drop_count
);

  localparam int FW    = PEAKS * FREQ_WIDTH;
  localparam int AW    = PEAKS * AMPL_WIDTH;
  localparam int EW    = TIME_WIDTH + FW + AW;
  localparam int GAP_W = $clog2(MIN_GAP + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = PTR_W + 1;
  localparam int DW    = $clog2(DISCARD + 2);

  localparam logic [GAP_W-1:0]     GAP_LOAD  = GAP_W'(MIN_GAP - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(1);
  localparam logic [CW-1:0]        DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [DW-1:0]        DISCARD_C = DW'(DISCARD);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t                 state_reg, state_next;
  logic [GAP_W-1:0]       gap_reg, gap_next;
  logic                   pending_reg, pending_next;
  logic [CNT_WIDTH-1:0]   overrun_reg, overrun_next;
  logic                   pend_eff;
  logic                   entering_issue;

  // ---------------------------------------------------------------- issue FSM
  always_comb begin
    state_next     = state_reg;
    gap_next       = gap_reg;
    pend_eff       = pending_reg & ~flush;
    pending_next   = pend_eff;
    overrun_next   = overrun_reg;
    entering_issue = 1'b0;

    case (state_reg)
      IDLE: begin
        if (fft_valid || pend_eff) state_next = ISSUE;
      end
      ISSUE: begin
        state_next = GAP;
        gap_next   = GAP_LOAD;
      end
      GAP: begin
        gap_next = gap_reg - GAP_W'(1);
        // Leaving on the last GAP cycle keeps pulses exactly MIN_GAP apart.
        if (gap_reg == GAP_LAST) state_next = (pend_eff || fft_valid) ? ISSUE : IDLE;
      end
      default: state_next = IDLE;
    endcase

    entering_issue = (state_next == ISSUE);

    if (fft_valid) begin
      if (entering_issue && !pend_eff) begin
        pending_next = 1'b0;
      end else if (pend_eff && !entering_issue) begin
        if (overrun_reg != CNT_MAX) overrun_next = overrun_reg + CNT_WIDTH'(1);
      end else begin
        pending_next = 1'b1;
      end
    end else if (entering_issue) begin
      pending_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      gap_reg     <= '0;
      pending_reg <= 1'b0;
      overrun_reg <= '0;
    end else begin
      state_reg   <= state_next;
      gap_reg     <= gap_next;
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
    end
  end

  assign peaks_valid   = (state_reg == ISSUE);
  assign busy          = (state_reg != IDLE) || pending_reg;
  assign overrun_count = overrun_reg;

  // ------------------------------------------------ result detection and FIFO
  logic [TIME_WIDTH-1:0] prev_counter_reg;
  logic [DW-1:0]         discard_reg;
  logic [TIME_WIDTH-1:0] seq_reg;
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic [CNT_WIDTH-1:0]  drop_reg;
  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [EW-1:0]         head;
  logic                  new_result, keep, full, push, pop, drop;

  assign new_result = (peaks_counter != prev_counter_reg);
  assign keep       = new_result && (discard_reg == '0) && !flush;
  assign res_valid  = (count_reg != '0);
  assign full       = (count_reg == DEPTH_C);
  assign pop        = res_valid && res_ready && !flush;
  assign push       = keep && (!full || pop);
  assign drop       = keep && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_counter_reg <= '0;
      discard_reg      <= DISCARD_C;
      seq_reg          <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      drop_reg         <= '0;
    end else begin
      prev_counter_reg <= peaks_counter;
      if (flush) begin
        discard_reg <= DISCARD_C;
        seq_reg     <= '0;
        wr_ptr_reg  <= '0;
        rd_ptr_reg  <= '0;
        count_reg   <= '0;
      end else begin
        if (new_result && discard_reg != '0) discard_reg <= discard_reg - DW'(1);
        // A dropped result still consumes a sequence number.
        if (keep) seq_reg <= seq_reg + TIME_WIDTH'(1);
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        count_reg <= count_reg + CW'(push) - CW'(pop);
      end
      if (drop && drop_reg != CNT_MAX) drop_reg <= drop_reg + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {seq_reg, peaks_freqs, peaks_ampls};
  end

  assign head       = mem[rd_ptr_reg];
  assign res_frame  = res_valid ? head[EW-1 -: TIME_WIDTH] : '0;
  assign res_freqs  = res_valid ? head[AW +: FW] : '0;
  assign res_ampls  = res_valid ? head[0 +: AW] : '0;
  assign drop_count = drop_reg;

endmodule
